// File: rtl/rpn_pkg.sv
// Shared opcode, error-code and FSM state encodings for the RPN execution core.
package rpn_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_PUSH  = 4'd1,
        OP_DROP  = 4'd2,
        OP_DUP   = 4'd3,
        OP_NEG   = 4'd4,
        OP_CLEAR = 4'd5,
        OP_SWAP  = 4'd6,
        OP_ADD   = 4'd7,
        OP_SUB   = 4'd8,
        OP_MUL   = 4'd9
    } rpn_op_e;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_UNDERFLOW = 2'd1,
        ERR_OVERFLOW  = 2'd2
    } rpn_err_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } rpn_state_e;

endpackage

// File: rtl/rpn_stack_ram.sv
// Single-port stack RAM: synchronous write, registered read, one access per cycle.
module rpn_stack_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];

    // Write-first: a write also returns the written word on the read port.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
            o_rdata       <= i_wdata;
        end else begin
            o_rdata <= r_mem[i_addr];
        end
    end

endmodule

// File: rtl/rpn_engine.sv
// RPN execution core: TOS register over a RAM-backed stack, executing stack and
// arithmetic commands accepted through a valid/ready handshake.
module rpn_engine
    import rpn_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic [DATA_WIDTH-1:0] top,
    output logic [ADDR_WIDTH:0]   depth,
    output logic                  full,
    output logic                  empty,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code
);

    localparam logic [ADDR_WIDTH:0]   LP_MAX   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   LP_ONE_D = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   LP_TWO_D = (ADDR_WIDTH+1)'(2);
    localparam logic [ADDR_WIDTH-1:0] LP_ONE_A = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LP_TWO_A = ADDR_WIDTH'(2);

    rpn_state_e            r_state, w_state_next;
    logic [ADDR_WIDTH:0]   r_depth, w_depth_next;
    logic [DATA_WIDTH-1:0] r_tos, w_tos_next;
    logic                  r_err, w_err_next;
    logic [1:0]            r_err_code, w_err_code_next;
    logic                  r_done, w_done_next;
    logic [3:0]            r_op, w_op_next;
    rpn_err_e              w_fault;

    logic                  w_we;
    logic                  w_ram_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_nos;
    logic [ADDR_WIDTH-1:0] w_tos_idx;
    logic [ADDR_WIDTH-1:0] w_nos_idx;
    logic [ADDR_WIDTH-1:0] w_rd_idx;
    logic                  w_full;
    logic                  w_empty;

    assign w_full    = (r_depth == LP_MAX);
    assign w_empty   = (r_depth == '0);
    assign w_tos_idx = r_depth[ADDR_WIDTH-1:0] - LP_ONE_A;
    assign w_nos_idx = r_depth[ADDR_WIDTH-1:0] - LP_TWO_A;

    // Read address follows the next depth, so the registered RAM output always
    // holds NOS for the depth in force; a write to that slot is returned directly.
    assign w_rd_idx   = w_depth_next[ADDR_WIDTH-1:0] - LP_TWO_A;
    assign w_ram_we   = w_we & ~reset;
    assign w_ram_addr = w_we ? w_waddr : w_rd_idx;

    rpn_stack_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .i_we   (w_ram_we),
        .i_addr (w_ram_addr),
        .i_wdata(w_wdata),
        .o_rdata(w_nos)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next    = r_state;
        w_depth_next    = r_depth;
        w_tos_next      = r_tos;
        w_err_next      = r_err;
        w_err_code_next = r_err_code;
        w_done_next     = 1'b0;
        w_op_next       = r_op;
        w_we            = 1'b0;
        w_waddr         = w_nos_idx;
        w_wdata         = r_tos;
        w_fault         = ERR_NONE;
        cmd_ready       = (r_state == ST_IDLE);

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_done_next = 1'b1;
                    case (cmd_op)
                        OP_PUSH: begin
                            if (w_full) begin
                                w_fault = ERR_OVERFLOW;
                            end else begin
                                w_we         = ~w_empty;
                                w_waddr      = w_tos_idx;
                                w_tos_next   = cmd_data;
                                w_depth_next = r_depth + LP_ONE_D;
                            end
                        end
                        OP_DROP: begin
                            if (w_empty) begin
                                w_fault = ERR_UNDERFLOW;
                            end else begin
                                w_tos_next   = (r_depth == LP_ONE_D) ? '0 : w_nos;
                                w_depth_next = r_depth - LP_ONE_D;
                            end
                        end
                        OP_DUP: begin
                            if (w_empty) begin
                                w_fault = ERR_UNDERFLOW;
                            end else if (w_full) begin
                                w_fault = ERR_OVERFLOW;
                            end else begin
                                w_we         = 1'b1;
                                w_waddr      = w_tos_idx;
                                w_depth_next = r_depth + LP_ONE_D;
                            end
                        end
                        OP_NEG: begin
                            if (w_empty) w_fault = ERR_UNDERFLOW;
                            else         w_tos_next = '0 - r_tos;
                        end
                        OP_CLEAR: begin
                            w_depth_next    = '0;
                            w_tos_next      = '0;
                            w_err_next      = 1'b0;
                            w_err_code_next = ERR_NONE;
                        end
                        OP_SWAP, OP_ADD, OP_SUB, OP_MUL: begin
                            if (r_depth < LP_TWO_D) begin
                                w_fault = ERR_UNDERFLOW;
                            end else begin
                                w_state_next = ST_READ;
                                w_done_next  = 1'b0;
                                w_op_next    = cmd_op;
                            end
                        end
                        default: ;
                    endcase
                    if (w_fault != ERR_NONE) begin
                        w_err_next = 1'b1;
                        if (!r_err) w_err_code_next = w_fault;
                    end
                end
            end
            ST_READ: begin
                w_state_next = ST_IDLE;
                w_done_next  = 1'b1;
                case (r_op)
                    OP_SWAP: begin
                        w_we       = 1'b1;
                        w_waddr    = w_nos_idx;
                        w_tos_next = w_nos;
                    end
                    OP_ADD: begin
                        w_tos_next   = w_nos + r_tos;
                        w_depth_next = r_depth - LP_ONE_D;
                    end
                    OP_SUB: begin
                        w_tos_next   = w_nos - r_tos;
                        w_depth_next = r_depth - LP_ONE_D;
                    end
                    OP_MUL: begin
                        w_tos_next   = w_nos * r_tos;
                        w_depth_next = r_depth - LP_ONE_D;
                    end
                    default: ;
                endcase
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_depth    <= '0;
            r_tos      <= '0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
            r_done     <= 1'b0;
            r_op       <= OP_NOP;
        end else begin
            r_depth    <= w_depth_next;
            r_tos      <= w_tos_next;
            r_err      <= w_err_next;
            r_err_code <= w_err_code_next;
            r_done     <= w_done_next;
            r_op       <= w_op_next;
        end
    end

    assign top      = r_tos;
    assign depth    = r_depth;
    assign full     = w_full;
    assign empty    = w_empty;
    assign done     = r_done;
    assign err      = r_err;
    assign err_code = r_err_code;

endmodule

// File: tb/tb_rpn_engine.sv
// Scoreboard bench for rpn_engine: a queue-based stack model predicts each
// command's retirement state; a monitor compares on every done pulse.
module tb_rpn_engine;

    localparam logic [3:0] NOP = 4'd0, PUSH = 4'd1, DROP = 4'd2, DUP = 4'd3,
                           NEG = 4'd4, CLR = 4'd5, SWAP = 4'd6, ADD = 4'd7,
                           SUB = 4'd8, MUL = 4'd9;
    localparam int MAXD = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_op = 4'd0;
    logic [7:0] cmd_data = 8'd0;
    logic [7:0] top;
    logic [6:0] depth;
    logic       full, empty, done, err;
    logic [1:0] err_code;

    rpn_engine #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .top(top), .depth(depth),
        .full(full), .empty(empty), .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] top;
        int         depth;
        logic       err;
        logic [1:0] code;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] m_stk[$];
    logic       m_err;
    logic [1:0] m_code;
    int         n_checks = 0;
    int         n_fail = 0;
    int         busy_cnt = 0;

    function automatic void chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_stk.delete();
        m_err  = 1'b0;
        m_code = 2'd0;
    endfunction

    // Behavioural stack semantics; pushes the expected post-retirement view.
    function automatic void model_apply(logic [3:0] op, logic [7:0] d);
        logic [1:0] fault = 2'd0;
        logic [7:0] a, b, t;
        exp_t e;
        int n = m_stk.size();
        case (op)
            PUSH: if (n == MAXD) fault = 2'd2; else m_stk.push_back(d);
            DROP: if (n == 0) fault = 2'd1; else void'(m_stk.pop_back());
            DUP: begin
                if (n == 0) fault = 2'd1;
                else if (n == MAXD) fault = 2'd2;
                else m_stk.push_back(m_stk[n-1]);
            end
            NEG: begin
                if (n == 0) fault = 2'd1;
                else begin t = m_stk[n-1]; t = -t; m_stk[n-1] = t; end
            end
            CLR: model_reset();
            SWAP, ADD, SUB, MUL: begin
                if (n < 2) fault = 2'd1;
                else begin
                    a = m_stk.pop_back();
                    b = m_stk.pop_back();
                    case (op)
                        SWAP: begin m_stk.push_back(a); m_stk.push_back(b); end
                        ADD:  m_stk.push_back(b + a);
                        SUB:  m_stk.push_back(b - a);
                        default: m_stk.push_back(8'((int'(b) * int'(a)) % 256));
                    endcase
                end
            end
            default: ;
        endcase
        if (fault != 2'd0) begin
            if (!m_err) m_code = fault;
            m_err = 1'b1;
        end
        e.top   = (m_stk.size() == 0) ? 8'd0 : m_stk[m_stk.size()-1];
        e.depth = m_stk.size();
        e.err   = m_err;
        e.code  = m_code;
        sb_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (!reset && !cmd_ready) busy_cnt++;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL done_without_cmd: done=1 with no command outstanding at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                chk("sb_top", int'(top), int'(e.top));
                chk("sb_depth", int'(depth), e.depth);
                chk("sb_full", int'(full), int'(e.depth == MAXD));
                chk("sb_empty", int'(empty), int'(e.depth == 0));
                chk("sb_err", int'(err), int'(e.err));
                chk("sb_err_code", int'(err_code), int'(e.code));
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: cmd_ready=0 expected 1 after 20 cycles");
        end
        model_apply(op, d);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = NOP;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: %0d retirements outstanding expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic expect_now(string name, int t, int dp, int e, int c);
        chk({name, "_top"}, int'(top), t);
        chk({name, "_depth"}, int'(depth), dp);
        chk({name, "_err"}, int'(err), e);
        chk({name, "_code"}, int'(err_code), c);
    endtask

    initial begin
        logic [3:0] op;
        int r;

        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_done", int'(done), 0);
        expect_now("rst", 0, 0, 0, 0);
        reset = 1'b0;

        issue(PUSH, 8'd3);
        issue(PUSH, 8'd4);
        busy_cnt = 0;
        issue(ADD, 8'd0);
        drain();
        chk("add_busy_cycles", busy_cnt, 1);
        expect_now("add", 7, 1, 0, 0);

        issue(CLR, 8'd0);
        issue(PUSH, 8'd2);
        issue(PUSH, 8'd5);
        issue(SUB, 8'd0);
        drain();
        expect_now("sub", 8'hFD, 1, 0, 0);
        issue(PUSH, 8'd16);
        issue(PUSH, 8'd16);
        issue(MUL, 8'd0);
        drain();
        expect_now("mul", 0, 2, 0, 0);

        issue(CLR, 8'd0);
        issue(PUSH, 8'd1);
        issue(PUSH, 8'd2);
        issue(SWAP, 8'd0);
        issue(DROP, 8'd0);
        drain();
        expect_now("swapdrop", 2, 1, 0, 0);
        issue(DUP, 8'd0);
        issue(ADD, 8'd0);
        drain();
        expect_now("dupadd", 4, 1, 0, 0);

        issue(CLR, 8'd0);
        issue(ADD, 8'd0);
        drain();
        expect_now("underflow", 0, 0, 1, 1);
        issue(PUSH, 8'd9);
        drain();
        expect_now("sticky", 9, 1, 1, 1);
        issue(CLR, 8'd0);
        drain();
        expect_now("clear", 0, 0, 0, 0);

        for (int i = 0; i < 64; i++) issue(PUSH, 8'(i));
        drain();
        chk("fill_full", int'(full), 1);
        issue(PUSH, 8'd99);
        drain();
        expect_now("overflow", 63, 64, 1, 2);
        for (int i = 0; i < 63; i++) issue(DROP, 8'd0);
        drain();
        expect_now("unwind", 0, 1, 1, 2);

        issue(CLR, 8'd0);
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 40) op = PUSH;
            else if (r < 42) op = CLR;
            else op = 4'($urandom_range(0, 15));
            if (op == CLR && r >= 42) op = NOP;
            issue(op, 8'($urandom));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        drain();

        issue(CLR, 8'd0);
        issue(PUSH, 8'd3);
        issue(PUSH, 8'd4);
        drain();
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = ADD;
        @(posedge clk);
        #1;
        chk("midread_ready", int'(cmd_ready), 0);
        cmd_valid = 1'b0;
        cmd_op    = NOP;
        #1 reset = 1'b1;
        #1;
        chk("async_ready", int'(cmd_ready), 1);
        chk("async_done", int'(done), 0);
        expect_now("async", 0, 0, 0, 0);
        model_reset();
        sb_q.delete();
        @(negedge clk);
        reset = 1'b0;
        issue(PUSH, 8'd7);
        drain();
        expect_now("post_reset", 7, 1, 0, 0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rpn_engine.md
Name: rpn_engine

Overview:
Parametrised RPN execution core: a hardware stack with a command interface that executes stack and arithmetic ops in place.
- Generalises the plain push/pop stack in data width and depth.
- Adds DUP/SWAP/ADD/SUB/MUL/NEG, operand-count checking, sticky error reporting and a valid/ready command handshake.
- Sits between the switch/button front-end and the 7-segment display driver.

Parameters:
DATA_WIDTH, 8, operand/result width, two's complement
ADDR_WIDTH, 6, stack depth = 2**ADDR_WIDTH entries total (TOS register + RAM)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
cmd_valid  in  1  command present
cmd_ready  out  1  engine can accept; command accepted when cmd_valid && cmd_ready
cmd_op  in  4  opcode (rpn_pkg)
cmd_data  in  DATA_WIDTH  operand for PUSH, ignored otherwise
top  out  DATA_WIDTH  top of stack; 0 when empty
depth  out  ADDR_WIDTH+1  entries on stack, 0..2**ADDR_WIDTH
full  out  1  depth == 2**ADDR_WIDTH
empty  out  1  depth == 0
done  out  1  one-cycle pulse when a command retires (success or error)
err  out  1  sticky error flag
err_code  out  2  NONE=0, UNDERFLOW=1, OVERFLOW=2; holds first error

Behaviour:
- Reset (async, active-high), required values: top=0, depth=0, err=0, err_code=0, done=0, cmd_ready=1, FSM=IDLE. Stack RAM contents are not cleared.
- Storage: TOS in a register; entries below TOS in sync-read/sync-write RAM at index depth-2 (NOS) downward.
- FSM states: IDLE, READ.
  - IDLE: cmd_ready=1.
  - READ: cmd_ready=0; commands offered in READ are not accepted.
- Single-cycle ops (IDLE→IDLE; state updates at the accept edge; done high the following cycle):
  - NOP=0: no change.
  - PUSH=1: RAM[depth-1]<=TOS if depth>0; TOS<=cmd_data; depth+1.
  - DROP=2: TOS<=RAM[depth-2] via the pre-issued read below; depth-1.
  - DUP=3: RAM[depth-1]<=TOS; depth+1.
  - NEG=4: TOS<=-TOS.
  - CLEAR=5: depth<=0, top=0, err/err_code cleared.
- Two-cycle ops (IDLE→READ→IDLE):
  - Cycle 1 (accept edge): NOS read issued.
  - Cycle 2 edge: result written; done pulses the cycle after.
  - SWAP=6: TOS<=NOS, RAM[depth-2]<=TOS.
  - ADD=7: TOS<=NOS+TOS, depth-1.
  - SUB=8: TOS<=NOS-TOS, depth-1.
  - MUL=9: TOS<=low DATA_WIDTH bits of NOS*TOS, depth-1.
  - Arithmetic wraps modulo 2**DATA_WIDTH; no overflow flag.
- DROP implementation: the RAM read address tracks depth-2 continuously, so NOS is always valid one cycle after any depth change. DROP uses this registered value, so DROP is single-cycle.
- Operand requirements: PUSH needs !full; DUP needs 1≤depth<max; DROP and NEG need depth≥1; SWAP and binary ops need depth≥2.
- Violation handling:
  - Command retires in one cycle with stack, TOS and depth unchanged; done pulses.
  - err<=1; err_code set to UNDERFLOW or OVERFLOW only if err was 0.
- Opcodes 10–15: treated as NOP.
- While err=1, commands still execute normally; err is cleared only by CLEAR or reset.
- Reset mid-READ: aborts the op; no partial write.

Decomposition:
- rpn_pkg: opcode localparams/enum, err_code values, FSM state enum.
- Sub-module rpn_stack_ram: parametrised single-port RAM, sync write and registered read, one access per cycle. The engine muxes the address between the write index and depth-2.

Test Plan:
- Reset, PUSH 3, PUSH 4, ADD → top=7, depth=1, done pulses twice for the pushes and once for ADD; cmd_ready low exactly one cycle during ADD.
- PUSH 2, PUSH 5, SUB → top=0xFD (8-bit); PUSH 16, PUSH 16, MUL → top=0x00 (wrap).
- PUSH 1, PUSH 2, SWAP, DROP → top=2, depth=1; DUP, ADD → top=4, depth=1.
- From empty, ADD → err=1, err_code=1, depth=0, top=0. PUSH 9 → top=9, err still 1. CLEAR → err=0, depth=0.
- Fill with 64 PUSHes (values 0..63) → full=1; PUSH 99 → err_code=2, top=63. 63 DROPs → top=0, depth=1, sequence verified in reverse.
- Assert reset asynchronously mid-READ of an ADD → outputs zero immediately without a clock edge. After release, PUSH 7 → top=7, depth=1.
